// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop synchronizer, tick divider, majority-vote
// bit decisions, and a receive FIFO of {perr, ferr, data} entries with sticky status.
module uart_rx_ovs #(
  parameter int FIFO_DEPTH = 32,
  parameter int OVS        = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   baud_div_i,
  input  logic                          rx_en_i,
  input  logic [1:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          rx_re_i,
  input  logic                          clr_i,
  input  logic                          rx_bit_i,
  output logic [7:0]                    dout_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  output logic                          break_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(OVS);

  localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
  localparam logic [TW-1:0] T_S2  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic rx_q1, rx_q2, rx_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q1   <= 1'b1;
      rx_q2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= rx_bit_i;
      rx_q2   <= rx_q1;
      rx_prev <= rx_q2;
    end
  end

  // >= rather than == so a divisor lowered mid-count cannot run the counter through a wrap
  logic [15:0] div_cnt, div_max;
  logic        tick;
  assign div_max = (baud_div_i == 16'd0) ? 16'd0 : baud_div_i - 16'd1;
  assign tick    = rx_en_i && (div_cnt >= div_max);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       div_cnt <= '0;
    else if (!rx_en_i) div_cnt <= '0;
    else if (tick)     div_cnt <= '0;
    else               div_cnt <= div_cnt + 16'd1;
  end

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    smp;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    data_r;
  logic          par_acc, perr_r, ferr_acc, any_one;
  logic [1:0]    nb_r;
  logic          pen_r, podd_r, stop2_r;

  logic       maj, mid_tick, last_stop, push, brk_frame;
  logic [9:0] wr_word;

  assign maj       = (smp[0] & smp[1]) | (smp[0] & rx_q2) | (smp[1] & rx_q2);
  assign mid_tick  = tick && (tick_cnt == T_S2);
  assign last_stop = (state == S_STOP) && (!stop2_r || stop_idx);
  assign push      = mid_tick && last_stop;
  // any_one covers every earlier bit; the final stop bit is the current decision
  assign brk_frame = !any_one && !maj;
  assign wr_word   = brk_frame ? 10'b01_0000_0000 : {perr_r, ferr_acc | !maj, data_r};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      smp      <= 2'b11;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_r   <= '0;
      par_acc  <= 1'b0;
      perr_r   <= 1'b0;
      ferr_acc <= 1'b0;
      any_one  <= 1'b0;
      nb_r     <= '0;
      pen_r    <= 1'b0;
      podd_r   <= 1'b0;
      stop2_r  <= 1'b0;
    end else if (!rx_en_i) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (rx_prev && !rx_q2) begin
        state    <= S_START;
        tick_cnt <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        data_r   <= '0;
        par_acc  <= 1'b0;
        perr_r   <= 1'b0;
        ferr_acc <= 1'b0;
        any_one  <= 1'b0;
        nb_r     <= data_bits_i;
        pen_r    <= parity_en_i;
        podd_r   <= parity_odd_i;
        stop2_r  <= stop2_i;
      end
    end else if (tick) begin
      tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + TW'(1);
      if (tick_cnt == T_S0) smp[0] <= rx_q2;
      if (tick_cnt == T_S1) smp[1] <= rx_q2;
      if (tick_cnt == T_S2) begin
        any_one <= any_one | maj;
        case (state)
          S_START: state <= maj ? S_IDLE : S_DATA;
          S_DATA: begin
            data_r[bit_idx] <= maj;
            par_acc         <= par_acc ^ maj;
            bit_idx         <= bit_idx + 3'd1;
            if (bit_idx == {1'b1, nb_r}) state <= pen_r ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            perr_r <= (par_acc ^ maj) != podd_r;
            state  <= S_STOP;
          end
          S_STOP: begin
            ferr_acc <= ferr_acc | !maj;
            stop_idx <= 1'b1;
            if (last_stop) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_pop, do_wr;

  assign full_o  = (level_o == DEPTH_L);
  assign empty_o = (level_o == '0);
  assign do_pop  = rx_re_i && !empty_o;
  assign do_wr   = push && (!full_o || do_pop);

  // when full with a simultaneous pop, wptr == rptr: the read sees the old entry
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      level_o   <= '0;
      dout_o    <= '0;
      perr_o    <= 1'b0;
      ferr_o    <= 1'b0;
      overrun_o <= 1'b0;
      break_o   <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_pop) begin
        rptr                     <= rptr + AW'(1);
        {perr_o, ferr_o, dout_o} <= mem[rptr];
      end
      case ({do_wr, do_pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
      if (push && full_o && !do_pop) overrun_o <= 1'b1;
      else if (clr_i)                overrun_o <= 1'b0;
      if (push && brk_frame)         break_o   <= 1'b1;
      else if (clr_i)                break_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: table of frame formats plus glitch, overrun,
// break, mid-frame reset and enable-drop sequences.
module tb_uart_rx_ovs;
  localparam int DEPTH = 8;
  localparam int OVS   = 16;
  localparam int BAUD  = 4;
  localparam int BIT   = BAUD * OVS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        rx_en, par_en, par_odd, stop2, rx_re, clr, rx;
  logic [1:0]  data_bits;
  logic [7:0]  dout;
  logic        perr, ferr, full, empty, overrun, brk;
  logic [$clog2(DEPTH):0] level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_ovs #(.FIFO_DEPTH(DEPTH), .OVS(OVS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .rx_en_i(rx_en),
    .data_bits_i(data_bits), .parity_en_i(par_en), .parity_odd_i(par_odd),
    .stop2_i(stop2), .rx_re_i(rx_re), .clr_i(clr), .rx_bit_i(rx),
    .dout_o(dout), .perr_o(perr), .ferr_o(ferr), .full_o(full), .empty_o(empty),
    .level_o(level), .overrun_o(overrun), .break_o(brk)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] nb;
    logic       pen, podd, s2, bad_par, bad_stop;
    logic [7:0] exp_d;
    logic       exp_perr, exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] nb, input logic pen, input logic podd, input logic s2);
    data_bits = nb; par_en = pen; par_odd = podd; stop2 = s2;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic pen,
                      input logic podd, input logic s2, input logic bad_par, input logic bad_stop);
    int   n;
    logic p;
    n = 5 + int'(nb);
    p = podd;
    hold_bit(1'b0, BIT);
    for (int i = 0; i < n; i++) begin
      hold_bit(d[i], BIT);
      p = p ^ d[i];
    end
    if (pen) hold_bit(p ^ bad_par, BIT);
    hold_bit(!bad_stop, BIT);
    if (s2) hold_bit(1'b1, BIT);
    hold_bit(1'b1, 2 * BIT);
  endtask

  task automatic pop();
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " dout"},    32'(dout),    32'h0);
    check({tag, " perr"},    32'(perr),    32'h0);
    check({tag, " ferr"},    32'(ferr),    32'h0);
    check({tag, " full"},    32'(full),    32'h0);
    check({tag, " empty"},   32'(empty),   32'h1);
    check({tag, " level"},   32'(level),   32'h0);
    check({tag, " overrun"}, 32'(overrun), 32'h0);
    check({tag, " break"},   32'(brk),     32'h0);
  endtask

  initial begin
    //          d      nb    pen   podd  s2    badp  bads  exp_d  perr  ferr
    vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h35, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0};
    vecs[2] = '{8'h12, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0};
    vecs[3] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0};
    vecs[4] = '{8'h2A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'hE3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};

    rst_n = 1'b0; baud_div = 16'(BAUD); rx_en = 1'b1; rx_re = 1'b0; clr = 1'b0; rx = 1'b1;
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    hold_bit(1'b1, 2 * BIT);

    for (int v = 0; v < 8; v++) begin
      cfg(vecs[v].nb, vecs[v].pen, vecs[v].podd, vecs[v].s2);
      send(vecs[v].d, vecs[v].nb, vecs[v].pen, vecs[v].podd, vecs[v].s2,
           vecs[v].bad_par, vecs[v].bad_stop);
      check($sformatf("vec%0d level1", v), 32'(level), 32'h1);
      pop();
      check($sformatf("vec%0d dout", v),   32'(dout),   32'(vecs[v].exp_d));
      check($sformatf("vec%0d perr", v),   32'(perr),   32'(vecs[v].exp_perr));
      check($sformatf("vec%0d ferr", v),   32'(ferr),   32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d level0", v), 32'(level), 32'h0);
    end

    // short low glitch on the idle line is rejected as a false start
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    hold_bit(1'b0, 5 * BAUD);
    hold_bit(1'b1, 3 * BIT);
    check("glitch level", 32'(level), 32'h0);
    check("glitch empty", 32'(empty), 32'h1);

    for (int i = 0; i <= DEPTH; i++) send(8'h30 + 8'(i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr full",    32'(full),    32'h1);
    check("ovr overrun", 32'(overrun), 32'h1);
    check("ovr level",   32'(level),   32'(DEPTH));
    pop();
    check("ovr first", 32'(dout), 32'h30);
    for (int i = 1; i < DEPTH; i++) pop();
    check("ovr last",  32'(dout),  32'h30 + 32'(DEPTH - 1));
    check("ovr empty", 32'(empty), 32'h1);
    pop();
    check("empty pop dout",  32'(dout),  32'h30 + 32'(DEPTH - 1));
    check("empty pop level", 32'(level), 32'h0);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr overrun", 32'(overrun), 32'h0);

    hold_bit(1'b0, 20 * BIT);
    hold_bit(1'b1, 3 * BIT);
    check("brk flag",  32'(brk),   32'h1);
    check("brk level", 32'(level), 32'h1);
    pop();
    check("brk dout", 32'(dout), 32'h0);
    check("brk ferr", 32'(ferr), 32'h1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr break", 32'(brk), 32'h0);

    // FIFO and dout left non-zero before a mid-frame reset
    send(8'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h66, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop();
    check("pre-rst dout", 32'(dout), 32'h77);
    hold_bit(1'b0, BIT);
    hold_bit(1'b1, 2 * BIT);
    hold_bit(1'b0, BIT);
    rst_n = 1'b0; rx = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_bit(1'b1, 2 * BIT);
    check("post-rst level", 32'(level), 32'h0);
    send(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post-rst level1", 32'(level), 32'h1);
    pop();
    check("post-rst dout", 32'(dout), 32'h5A);
    check("post-rst perr", 32'(perr), 32'h0);
    check("post-rst ferr", 32'(ferr), 32'h0);

    // dropping enable mid-frame discards it
    hold_bit(1'b0, BIT);
    hold_bit(1'b1, 3 * BIT);
    rx_en = 1'b0;
    hold_bit(1'b1, 4 * BIT);
    rx_en = 1'b1;
    hold_bit(1'b1, 12 * BIT);
    check("rxen level", 32'(level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, receive FIFO entries; a power of two, 4 or more.
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit; even, 8 or more.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port baud_div_i  in  16  clk_i cycles per oversample tick; value 0 is treated as 1.
REQ-006 SHALL have port rx_en_i  in  1  receiver enable.
REQ-007 SHALL have port data_bits_i  in  2  data bits per frame: 0 -> 5, 1 -> 6, 2 -> 7, 3 -> 8.
REQ-008 SHALL have port parity_en_i  in  1  enables the parity bit.
REQ-009 SHALL have port parity_odd_i  in  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port stop2_i  in  1  1 = two stop bits, 0 = one stop bit.
REQ-011 SHALL have port rx_re_i  in  1  pop request.
REQ-012 SHALL have port clr_i  in  1  clears the sticky status flags.
REQ-013 SHALL have port rx_bit_i  in  1  asynchronous serial input; idles high.
REQ-014 SHALL have port dout_o  out  8  popped data byte; unused upper bits are 0.
REQ-015 SHALL have port perr_o, ferr_o  out  1 each  parity error and framing error of the popped entry.
REQ-016 SHALL have port full_o, empty_o  out  1 each  FIFO full and FIFO empty.
REQ-017 SHALL have port level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port overrun_o, break_o  out  1 each  sticky overrun flag and sticky break flag.

Function
REQ-019 SHALL pass rx_bit_i through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
REQ-020 SHALL pulse a tick for 1 cycle when the divider counter equals baud_div_i-1, then reload the counter to 0; the counter is held at 0 while rx_en_i=0.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-022 In IDLE, a synchronized 1->0 transition SHALL move to START, clear the tick count, and latch data_bits_i, parity_en_i, parity_odd_i and stop2_i for the whole frame.
REQ-023 Every bit value SHALL be the 2-of-3 majority of samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1 within the bit.
REQ-024 START: a majority of 1 SHALL return the FSM to IDLE with no push (false start); a majority of 0 SHALL move it to DATA.
REQ-025 DATA SHALL shift in bits LSB first, each bit OVS ticks after the previous one; after N bits it moves to PARITY if parity is enabled, otherwise to STOP.
REQ-026 PARITY: perr SHALL be set when the XOR of the data bits and the parity bit differs from parity_odd.
REQ-027 STOP: ferr SHALL be set when any stop-bit sample is 0.
REQ-028 The push SHALL occur at the mid-bit decision of the final stop bit, and the FSM returns to IDLE in that same cycle so the next start edge can be detected.
REQ-029 A frame SHALL be treated as a break when all data bits, the parity bit (if enabled) and the stop bit(s) are 0; it sets break_o and pushes 0x00 with ferr=1.
REQ-030 Each FIFO entry SHALL hold {perr, ferr, data[7:0]}.
REQ-031 A pop SHALL require rx_re_i=1 and empty_o=0; dout_o, perr_o and ferr_o update on the next edge and hold until the next pop.
REQ-032 A pop while empty SHALL be ignored, with outputs unchanged.
REQ-033 A push while full, with no pop in the same cycle, SHALL drop the frame and set overrun_o.
REQ-034 A push and a pop in the same cycle SHALL both be accepted, including when the FIFO is full; level_o is unchanged.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 full_o SHALL equal (level_o == FIFO_DEPTH), and empty_o SHALL equal (level_o == 0).
REQ-037 clr_i SHALL clear overrun_o and break_o; if clr_i and a setting event occur in the same cycle, the set wins.
REQ-038 rx_en_i=0 SHALL force the FSM to IDLE, discard any partial frame, and keep the FIFO contents and pops working.

Reset
REQ-039 While rst_ni=0, the FSM SHALL be in IDLE, the pointers, level and counters 0, the synchronizer 1, dout_o, perr_o, ferr_o, full_o, overrun_o and break_o 0, and empty_o 1.
REQ-040 When rst_ni asserts mid-frame, the partial frame SHALL be discarded with no push.

Verification
REQ-041 baud_div=4, 8N1, byte 0xA5 -> after 1 pop: dout_o=0xA5, perr_o=0, ferr_o=0, level returns to 0.
REQ-042 7O2, byte 0x35 sent with a wrong parity bit -> perr_o=1; the next frame 0x12 with correct parity -> perr_o=0.
REQ-043 A 0 glitch shorter than OVS/2 ticks on the idle line -> no push, level_o stays 0.
REQ-044 Send FIFO_DEPTH+1 frames with no pops -> full_o=1, overrun_o=1, level_o=FIFO_DEPTH; the first and last popped bytes match frames 1 and FIFO_DEPTH; clr_i clears overrun_o.
REQ-045 Line held low for 2 frame times -> break_o=1, and the entry pops as 0x00 with ferr_o=1.
REQ-046 rst_ni pulsed low mid-frame -> all outputs at reset values, and the next full frame is received correctly.
